// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard; x0 is hardwired zero.
// Optional same-cycle writeback forwarding under REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     pending_cnt,
  output logic            wb_err
);

  localparam int NREGS = 2 ** AW;

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nx;

  logic wb_do;
  logic iss_fire;
  logic same_rd;
  logic cnt_inc;
  logic cnt_dec;

  assign wb_do    = wb_valid && (wb_rd != '0);
  assign same_rd  = wb_valid && (wb_rd == iss_rd);
  assign iss_ready = (iss_rd == '0) || !busy[iss_rd] || same_rd;
  assign iss_fire = iss_valid && iss_ready && (iss_rd != '0);

  assign cnt_inc = iss_fire && !busy[iss_rd];
  assign cnt_dec = wb_do && busy[wb_rd] &&
                   !(iss_fire && iss_rd == wb_rd);

  // Next scoreboard: writeback clears, issue sets and wins on a tie.
  always_comb begin
    busy_nx = busy;
    if (wb_do)
      busy_nx[wb_rd] = 1'b0;
    if (iss_fire)
      busy_nx[iss_rd] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  // Register storage, scoreboard, pending count and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      if (wb_do) begin
        regs[wb_rd] <= wb_data;
        if (!busy[wb_rd])
          wb_err <= 1'b1;
      end
      busy        <= busy_nx;
      pending_cnt <= pending_cnt
                   + {{AW{1'b0}}, cnt_inc}
                   - {{AW{1'b0}}, cnt_dec};
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;
  assign fwd1 = wb_do && (wb_rd == rs1);
  assign fwd2 = wb_do && (wb_rd == rs2);

  // Operand reads with writeback forwarding.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    busy1  = busy[rs1];
    busy2  = busy[rs2];
    if (rs1 != '0)
      rdata1 = fwd1 ? wb_data : regs[rs1];
    if (rs2 != '0)
      rdata2 = fwd2 ? wb_data : regs[rs2];
    if (fwd1)
      busy1 = 1'b0;
    if (fwd2)
      busy2 = 1'b0;
  end
`else
  // Operand reads straight from storage.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    busy1  = busy[rs1];
    busy2  = busy[rs2];
    if (rs1 != '0)
      rdata1 = regs[rs1];
    if (rs2 != '0)
      rdata2 = regs[rs2];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a cycle-level reference model.
// Literal checks pin the model on the documented scenarios.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  pending_cnt;
  logic        wb_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit en = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2),
    .busy1(busy1), .busy2(busy2),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_err;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit fwd(logic [4:0] r);
    return BYP && wb_valid && wb_rd == r && r != 0;
  endfunction

  function automatic logic [31:0] e_rd(logic [4:0] r);
    if (r == 0) return 32'h0;
    if (fwd(r)) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit e_busy(logic [4:0] r);
    if (r == 0 || fwd(r)) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic bit e_ready();
    return iss_rd == 0 || !m_busy[iss_rd] ||
           (wb_valid && wb_rd == iss_rd);
  endfunction

  function automatic int e_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++)
      c += int'(m_busy[i]);
    return c;
  endfunction

  // Reference model: architectural effect of one cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'h0;
        m_busy[i] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        m_regs[wb_rd] <= wb_data;
        if (!m_busy[wb_rd]) m_err <= 1'b1;
        m_busy[wb_rd] <= 1'b0;
      end
      if (iss_valid && e_ready() && iss_rd != 0)
        m_busy[iss_rd] <= 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (en && !reset) begin
      chk("m_rdata1", rdata1, e_rd(rs1));
      chk("m_rdata2", rdata2, e_rd(rs2));
      chk("m_busy1", busy1, e_busy(rs1));
      chk("m_busy2", busy2, e_busy(rs2));
      chk("m_ready", iss_ready, e_ready());
      chk("m_cnt", pending_cnt, e_cnt());
      chk("m_err", wb_err, m_err);
    end
  end

  task automatic cyc(bit iv, logic [4:0] ir, bit wv,
                     logic [4:0] wr, logic [31:0] wd);
    @(posedge clk);
    #1;
    iss_valid = iv;
    iss_rd    = ir;
    wb_valid  = wv;
    wb_rd     = wr;
    wb_data   = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    rs1 = 0; rs2 = 0;
    iss_valid = 0; iss_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    en = 1;
    @(negedge clk);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_ready", iss_ready, 1);

    rs1 = 7;
    cyc(1, 7, 0, 0, 0);
    chk("iss7_ready", iss_ready, 1);
    chk("iss7_busy_pre", busy1, 0);
    idle();
    chk("iss7_busy", busy1, 1);
    chk("iss7_cnt", pending_cnt, 1);
    cyc(0, 0, 1, 7, 32'hDEADBEEF);
    chk("wb7_same_rd", rdata1, BYP ? 32'hDEADBEEF : 0);
    chk("wb7_same_busy", busy1, BYP ? 0 : 1);
    idle();
    chk("wb7_rd", rdata1, 32'hDEADBEEF);
    chk("wb7_busy", busy1, 0);
    chk("wb7_cnt", pending_cnt, 0);

    rs1 = 3;
    cyc(1, 3, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    chk("waw_block", iss_ready, 0);
    chk("waw_cnt", pending_cnt, 1);
    cyc(1, 3, 1, 3, 32'h55);
    chk("waw_release", iss_ready, 1);
    idle();
    chk("waw_busy", busy1, 1);
    chk("waw_rd", rdata1, 32'h55);
    chk("waw_cnt2", pending_cnt, 1);
    cyc(0, 0, 1, 3, 32'h56);
    idle();
    chk("waw_clr_cnt", pending_cnt, 0);

    rs1 = 0;
    cyc(1, 0, 0, 0, 0);
    chk("x0_ready", iss_ready, 1);
    idle();
    chk("x0_cnt", pending_cnt, 0);
    cyc(0, 0, 1, 0, 32'hFFFFFFFF);
    idle();
    chk("x0_rd", rdata1, 0);
    chk("x0_err", wb_err, 0);

    rs1 = 9;
    cyc(0, 0, 1, 9, 32'hA5);
    idle();
    chk("spur_rd", rdata1, 32'hA5);
    chk("spur_err", wb_err, 1);
    cyc(1, 10, 0, 0, 0);
    cyc(1, 11, 1, 10, 32'h10);
    cyc(0, 0, 1, 11, 32'h11);
    idle();
    chk("spur_sticky", wb_err, 1);
    chk("traffic_cnt", pending_cnt, 0);

    rs2 = 4;
    cyc(1, 4, 0, 0, 0);
    cyc(0, 0, 1, 4, 32'h77);
    chk("byp_rd2", rdata2, BYP ? 32'h77 : 0);
    chk("byp_busy2", busy2, BYP ? 0 : 1);
    idle();
    chk("byp_rd2_nx", rdata2, 32'h77);
    chk("byp_busy2_nx", busy2, 0);

    rs1 = 5;
    cyc(1, 5, 0, 0, 0);
    cyc(1, 5, 1, 5, 32'h1234);
    idle();
    chk("pre_rst_rd", rdata1, 32'h1234);
    chk("pre_rst_busy", busy1, 1);
    chk("pre_rst_err", wb_err, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rd", rdata1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_cnt", pending_cnt, 0);
    chk("mid_rst_err", wb_err, 0);
    #1 reset = 1'b0;
    idle();
    chk("post_rst_rd2", rdata2, 0);
    cyc(1, 12, 0, 0, 0);
    cyc(1, 13, 0, 0, 0);
    idle();
    chk("post_rst_cnt", pending_cnt, 2);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated pending-write scoreboard. It is the successor to the single-cycle core's two-read/one-write register file and serves the pipelined and multi-cycle cores, where a destination register is reserved at issue and written at a later writeback. The block provides combinational operand reads with per-operand busy flags, issue-side reservation with write-after-write (WAW) blocking, writeback with busy clearing, a pending-register count and a sticky protocol-error flag. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- XLEN, 32, data width in bits
- AW, 5, register index width; NREGS = 2**AW registers

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- rs1, rs2  in  AW  read indices
- rdata1, rdata2  out  XLEN  read data, combinational
- busy1, busy2  out  1  scoreboard bit of rs1/rs2, combinational
- iss_valid  in  1  issue request reserving iss_rd
- iss_rd  in  AW  destination being reserved
- iss_ready  out  1  issue accepted this cycle, combinational
- wb_valid  in  1  writeback strobe
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- pending_cnt  out  AW+1  number of busy registers, registered
- wb_err  out  1  sticky: writeback hit a non-busy register, registered

## Operation
- Storage: NREGS x XLEN registers plus busy[NREGS-1:0]; busy[0] is constant 0.
- Read: rdataN = 0 when rsN == 0, else regs[rsN]; busyN = busy[rsN].
- iss_ready = !busy[iss_rd] || (wb_valid && wb_rd == iss_rd). iss_rd == 0 always reads as ready.
- Issue fires when iss_valid && iss_ready. At the next edge it sets busy[iss_rd]; iss_rd == 0 is accepted with no state change.
- Writeback when wb_valid with wb_rd != 0:
  - regs[wb_rd] <= wb_data at the edge.
  - busy[wb_rd] <= 0, unless an issue fires to the same register that cycle, in which case issue wins and busy stays 1.
- Writeback with wb_rd == 0 is ignored entirely: no write, no error.
- Writeback with wb_rd != 0 and busy[wb_rd] == 0 still writes the data and sets wb_err; wb_err is cleared only by reset.
- Issue and writeback to different registers in the same cycle are independent.
- pending_cnt tracks popcount(busy) and is updated at the same edge as busy, as follows:
  - +1 when an issue sets a previously clear bit.
  - -1 when a writeback clears a bit.
  - Net 0 for a same-register issue+writeback.
  - Never wraps, because its maximum is NREGS-1.
- Reset, asserted at any time including mid-operation: all regs = 0, busy = 0, pending_cnt = 0, wb_err = 0. Any in-flight reservation is dropped.

## Timing
- Read latency 0, purely combinational from rsN.
- Writeback data is visible on rdataN from the cycle after wb_valid (same cycle under REGFILE_BYPASS_EN).
- Issue reservation is visible on busyN, iss_ready and pending_cnt from the cycle after the accepted issue.
- iss_ready has a combinational path from iss_rd, wb_valid and wb_rd only, never from iss_valid.
- No output has a combinational path from iss_valid.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding applies when wb_valid && wb_rd == rsN && rsN != 0. In that case:
  - rdataN = wb_data in the same cycle.
  - busyN = 0 in the same cycle.
- REGFILE_BYPASS_EN undefined: for that cycle, rdataN shows the old register value and busyN shows the current busy bit. New data and cleared busy appear the next cycle.
- Stored state and all sequential behaviour are identical in both builds.

## Test plan
- Reset mid-run: with r5 busy, r5 = 0x1234 and wb_err = 1, pulse reset between clock edges -> immediately rdata (rs1 = 5) = 0, busy1 = 0, pending_cnt = 0, wb_err = 0.
- Basic flow: issue r7 -> next cycle busy1 (rs1 = 7) = 1 and pending_cnt = 1. Writeback r7 = 0xDEADBEEF -> next cycle rdata1 = 0xDEADBEEF, busy1 = 0, pending_cnt = 0.
- WAW block and release: with r3 busy, iss_rd = 3 and no writeback -> iss_ready = 0. Same cycle writeback r3 = 0x55 plus issue r3 -> iss_ready = 1; next cycle busy = 1, rdata = 0x55, pending_cnt unchanged.
- x0 handling:
  - Issue r0 -> iss_ready = 1, pending_cnt stays 0.
  - Writeback r0 = 0xFFFFFFFF -> rdata (rs = 0) = 0, wb_err = 0.
- Spurious writeback: writeback r9 = 0xA5 with busy[9] = 0 -> next cycle rdata = 0xA5 and wb_err = 1. wb_err stays 1 across further valid traffic.
- Bypass: writeback r4 = 0x77 with rs2 = 4.
  - With REGFILE_BYPASS_EN: same cycle rdata2 = 0x77, busy2 = 0.
  - Without it: same cycle rdata2 = old value, busy2 = 1; next cycle rdata2 = 0x77, busy2 = 0.
